// File: rtl/gpio_regfile_pkg.sv
// Shared opcodes, field positions and read-source encoding for the GPIO command register file.
package gpio_regfile_pkg;

  localparam logic [7:0] OPC_RST    = 8'h01;
  localparam logic [7:0] OPC_LOG    = 8'h03;
  localparam logic [7:0] OPC_RAM_RD = 8'h04;
  localparam logic [7:0] OPC_SNAP   = 8'h05;
  localparam logic [7:0] OPC_CNT_RD = 8'h06;
  localparam logic [7:0] OPC_STS    = 8'h07;

  localparam int STROBE_BIT = 23;

  localparam logic [7:0] REGFILE_VERSION = 8'h02;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_RAM,
    SRC_CNT,
    SRC_STS
  } rd_src_e;

endpackage

// File: rtl/gpio_regfile_cnt_snapshot.sv
// Counter snapshot bank: captures all channels together on i_capture, one cycle to visible.
// Word mux is combinational over the captured bank; out-of-range indices read zero; no backpressure.
module cnt_snapshot
  import gpio_regfile_pkg::*;
#(
  parameter int NBT_GPIOS = 32,
  parameter int NB_CNT    = 64,
  parameter int NUM_CH    = 4
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic [NUM_CH*NB_CNT-1:0] i_cnt_flat,
  input  logic                     i_capture,
  input  logic [7:0]               i_idx,
  output logic [NBT_GPIOS-1:0]     o_word
);

  localparam int W = NB_CNT / NBT_GPIOS;

  logic [NB_CNT-1:0] snap_q [NUM_CH];
  logic [NB_CNT-1:0] snap_d [NUM_CH];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      snap_d[c] = snap_q[c];
      if (i_capture) snap_d[c] = i_cnt_flat[c*NB_CNT +: NB_CNT];
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int c = 0; c < NUM_CH; c++) snap_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) snap_q[c] <= snap_d[c];
    end
  end

  // idx = ch*W + word; anything past the last channel falls through to zero
  always_comb begin
    o_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int w = 0; w < W; w++) begin
        if (int'(i_idx) == c*W + w) o_word = snap_q[c][w*NBT_GPIOS +: NBT_GPIOS];
      end
    end
  end

endmodule

// File: rtl/gpio_regfile.sv
// GPIO command decoder/register file for the DSP; commands accepted on strobe rising edge, readback 1 cycle.
// No backpressure; optional input synchronizer via GPIO_REGFILE_CDC_SYNC_EN adds 3 cycles of acceptance latency.
module gpio_regfile
  import gpio_regfile_pkg::*;
#(
  parameter int NBT_GPIOS  = 32,
  parameter int NB_CNT     = 64,
  parameter int NUM_CH     = 4,
  parameter int NBT_ADRS   = 16,
  parameter int RST_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic [NBT_GPIOS-1:0]     i_gpio_cmd,
  output logic [NBT_GPIOS-1:0]     o_gpio_rdata,
  input  logic [NBT_GPIOS-1:0]     i_ram_rdata,
  input  logic [NUM_CH*NB_CNT-1:0] i_cnt_flat,
  output logic                     o_rst_dsp,
  output logic [2:0]               o_log_sel,
  output logic                     o_log_wr_en,
  output logic                     o_ram_rd_en,
  output logic [NBT_ADRS-1:0]      o_ram_rd_adrs,
  output logic                     o_snap_valid,
  output logic                     o_cmd_ack
);

  localparam int RCW = $clog2(RST_CYCLES + 1);

  logic [NBT_GPIOS-1:0] cmd_w;

`ifdef GPIO_REGFILE_CDC_SYNC_EN
  logic [NBT_GPIOS-1:0] sync1_q, sync1_d, sync2_q, sync2_d, cmd_cap_q, cmd_cap_d;

  // a multi-bit word only moves on once two back-to-back samples agree
  always_comb begin
    sync1_d   = i_gpio_cmd;
    sync2_d   = sync1_q;
    cmd_cap_d = cmd_cap_q;
    if (sync2_q == sync1_q) cmd_cap_d = sync2_q;
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cmd_cap_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cmd_cap_q <= cmd_cap_d;
    end
  end

  assign cmd_w = cmd_cap_q;
`else
  assign cmd_w = i_gpio_cmd;
`endif

  logic                 strb_prev_q, strb_prev_d;
  logic                 ack_q, ack_d;
  logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
  logic [2:0]           log_sel_q, log_sel_d;
  logic                 log_wr_en_q, log_wr_en_d;
  logic [NBT_ADRS-1:0]  ram_adrs_q, ram_adrs_d;
  logic [7:0]           cnt_idx_q, cnt_idx_d;
  rd_src_e              sel_q, sel_d;
  logic                 cont_q, cont_d;
  logic                 snap_valid_q, snap_valid_d;
  logic [NBT_GPIOS-1:0] rdata_q, rdata_d;

  logic                 accept;
  logic [7:0]           opc;
  logic                 capture;
  logic [NBT_GPIOS-1:0] snap_word;
  logic [31:0]          sts32;
  logic [NBT_GPIOS-1:0] sts_word;
  logic                 unused_cmd;

  assign opc        = cmd_w[31:24];
  assign accept     = cmd_w[STROBE_BIT] & ~strb_prev_q;
  assign sts32      = {8'(NUM_CH), 8'(NB_CNT), REGFILE_VERSION, 7'b0, snap_valid_q};
  assign sts_word   = NBT_GPIOS'(sts32);
  assign unused_cmd = ^cmd_w;

  always_comb begin
    strb_prev_d  = cmd_w[STROBE_BIT];
    ack_d        = 1'b0;
    rst_cnt_d    = rst_cnt_q;
    log_sel_d    = log_sel_q;
    log_wr_en_d  = log_wr_en_q;
    ram_adrs_d   = ram_adrs_q;
    cnt_idx_d    = cnt_idx_q;
    sel_d        = sel_q;
    cont_d       = cont_q;
    snap_valid_d = snap_valid_q;
    capture      = cont_q;

    if (rst_cnt_q != '0) rst_cnt_d = rst_cnt_q - RCW'(1);

    if (accept) begin
      case (opc)
        OPC_RST: begin
          ack_d     = 1'b1;
          rst_cnt_d = cmd_w[0] ? RCW'(RST_CYCLES) : '0;
        end
        OPC_LOG: begin
          ack_d       = 1'b1;
          log_sel_d   = cmd_w[2:0];
          log_wr_en_d = cmd_w[3];
        end
        OPC_RAM_RD: begin
          ack_d      = 1'b1;
          ram_adrs_d = cmd_w[NBT_ADRS-1:0];
          if (cmd_w[16])              sel_d = SRC_RAM;
          else if (sel_q == SRC_RAM)  sel_d = SRC_NONE;
        end
        OPC_SNAP: begin
          ack_d  = 1'b1;
          cont_d = cmd_w[1];
          if (cmd_w[0] | cmd_w[1]) begin
            capture      = 1'b1;
            snap_valid_d = 1'b1;
          end else begin
            snap_valid_d = 1'b0;
          end
        end
        OPC_CNT_RD: begin
          ack_d     = 1'b1;
          cnt_idx_d = cmd_w[7:0];
          if (cmd_w[8])               sel_d = SRC_CNT;
          else if (sel_q == SRC_CNT)  sel_d = SRC_NONE;
        end
        OPC_STS: begin
          ack_d = 1'b1;
          if (cmd_w[0])               sel_d = SRC_STS;
          else if (sel_q == SRC_STS)  sel_d = SRC_NONE;
        end
        default: ;
      endcase
    end

    case (sel_q)
      SRC_RAM: rdata_d = i_ram_rdata;
      SRC_CNT: rdata_d = snap_word;
      SRC_STS: rdata_d = sts_word;
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      strb_prev_q  <= 1'b1;
      ack_q        <= 1'b0;
      rst_cnt_q    <= '0;
      log_sel_q    <= '0;
      log_wr_en_q  <= 1'b0;
      ram_adrs_q   <= '0;
      cnt_idx_q    <= '0;
      sel_q        <= SRC_NONE;
      cont_q       <= 1'b0;
      snap_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      strb_prev_q  <= strb_prev_d;
      ack_q        <= ack_d;
      rst_cnt_q    <= rst_cnt_d;
      log_sel_q    <= log_sel_d;
      log_wr_en_q  <= log_wr_en_d;
      ram_adrs_q   <= ram_adrs_d;
      cnt_idx_q    <= cnt_idx_d;
      sel_q        <= sel_d;
      cont_q       <= cont_d;
      snap_valid_q <= snap_valid_d;
      rdata_q      <= rdata_d;
    end
  end

  cnt_snapshot #(
    .NBT_GPIOS (NBT_GPIOS),
    .NB_CNT    (NB_CNT),
    .NUM_CH    (NUM_CH)
  ) u_snap (
    .clk        (clk),
    .i_reset    (i_reset),
    .i_cnt_flat (i_cnt_flat),
    .i_capture  (capture),
    .i_idx      (cnt_idx_q),
    .o_word     (snap_word)
  );

  assign o_gpio_rdata  = rdata_q;
  assign o_rst_dsp     = (rst_cnt_q != '0);
  assign o_log_sel     = log_sel_q;
  assign o_log_wr_en   = log_wr_en_q;
  assign o_ram_rd_en   = (sel_q == SRC_RAM);
  assign o_ram_rd_adrs = ram_adrs_q;
  assign o_snap_valid  = snap_valid_q;
  assign o_cmd_ack     = ack_q;

endmodule

// File: tb/tb_gpio_regfile.sv
// Scenario bench for gpio_regfile: commands driven on the falling edge, outputs sampled on the falling edge.
module tb_gpio_regfile;

  localparam int NBT_GPIOS  = 32;
  localparam int NB_CNT     = 64;
  localparam int NUM_CH     = 4;
  localparam int NBT_ADRS   = 16;
  localparam int RST_CYCLES = 16;

  logic                     clk;
  logic                     i_reset;
  logic [NBT_GPIOS-1:0]     i_gpio_cmd;
  logic [NBT_GPIOS-1:0]     o_gpio_rdata;
  logic [NBT_GPIOS-1:0]     i_ram_rdata;
  logic [NUM_CH*NB_CNT-1:0] i_cnt_flat;
  logic                     o_rst_dsp;
  logic [2:0]               o_log_sel;
  logic                     o_log_wr_en;
  logic                     o_ram_rd_en;
  logic [NBT_ADRS-1:0]      o_ram_rd_adrs;
  logic                     o_snap_valid;
  logic                     o_cmd_ack;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  gpio_regfile #(
    .NBT_GPIOS (NBT_GPIOS), .NB_CNT (NB_CNT), .NUM_CH (NUM_CH),
    .NBT_ADRS (NBT_ADRS), .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk (clk), .i_reset (i_reset), .i_gpio_cmd (i_gpio_cmd), .o_gpio_rdata (o_gpio_rdata),
    .i_ram_rdata (i_ram_rdata), .i_cnt_flat (i_cnt_flat), .o_rst_dsp (o_rst_dsp),
    .o_log_sel (o_log_sel), .o_log_wr_en (o_log_wr_en), .o_ram_rd_en (o_ram_rd_en),
    .o_ram_rd_adrs (o_ram_rd_adrs), .o_snap_valid (o_snap_valid), .o_cmd_ack (o_cmd_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe low for one cycle, then the full word; returns at the first falling edge showing ack
  task automatic send_cmd(input logic [31:0] w, output bit acked);
    acked = 1'b0;
    @(negedge clk); i_gpio_cmd = w & 32'hFF7F_FFFF;
    @(negedge clk); i_gpio_cmd = w;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_cmd_ack === 1'b1) begin acked = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_gpio_cmd = '0; i_ram_rdata = '0; i_cnt_flat = '0;
    repeat (3) @(negedge clk);
    checks++; if (o_gpio_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", o_gpio_rdata); end
    checks++; if (o_rst_dsp !== 1'b0) begin errors++; $display("FAIL reset_rst_dsp got %b want 0", o_rst_dsp); end
    checks++; if (o_log_sel !== 3'd0 || o_log_wr_en !== 1'b0) begin errors++; $display("FAIL reset_log got %h/%b want 0/0", o_log_sel, o_log_wr_en); end
    checks++; if (o_ram_rd_en !== 1'b0 || o_ram_rd_adrs !== 16'h0) begin errors++; $display("FAIL reset_ram got %b/%h want 0/0", o_ram_rd_en, o_ram_rd_adrs); end
    checks++; if (o_snap_valid !== 1'b0 || o_cmd_ack !== 1'b0) begin errors++; $display("FAIL reset_snap_ack got %b/%b want 0/0", o_snap_valid, o_cmd_ack); end
    i_reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_log();
    int acks;
    acks = 0;
    i_gpio_cmd = 32'h0300_0A0B;
    @(negedge clk); i_gpio_cmd = 32'h0380_0A0B;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_cmd_ack === 1'b1) acks++;
    end
    checks++; if (acks != 1) begin errors++; $display("FAIL log_ack_count got %0d want 1", acks); end
    checks++; if (o_log_sel !== 3'd3) begin errors++; $display("FAIL log_sel got %0d want 3", o_log_sel); end
    checks++; if (o_log_wr_en !== 1'b1) begin errors++; $display("FAIL log_wr_en got %b want 1", o_log_wr_en); end
  endtask

  task automatic test_rst_pulse();
    bit ack;
    int hi;
    send_cmd(32'h0180_0001, ack);
    hi = 0;
    for (int i = 1; i <= 60; i++) begin
      if (i > 1) @(negedge clk);
      if (o_rst_dsp === 1'b1) hi++;
    end
    checks++; if (!ack || hi != RST_CYCLES) begin errors++; $display("FAIL rst_single got ack=%b len=%0d want ack=1 len=%0d", ack, hi, RST_CYCLES); end

    send_cmd(32'h0180_0001, ack);
    hi = 0;
    for (int i = 1; i <= 60; i++) begin
      if (i > 1) @(negedge clk);
      if (o_rst_dsp === 1'b1) hi++;
      if (i == 7) i_gpio_cmd = 32'h0100_0001;
      if (i == 8) i_gpio_cmd = 32'h0180_0001;
    end
    checks++; if (hi != 24) begin errors++; $display("FAIL rst_reissue got len=%0d want 24", hi); end

    send_cmd(32'h0180_0001, ack);
    repeat (3) @(negedge clk);
    checks++; if (o_rst_dsp !== 1'b1) begin errors++; $display("FAIL rst_midpulse_pre got %b want 1", o_rst_dsp); end
    i_reset = 1'b0;
    #1;
    checks++; if (o_rst_dsp !== 1'b0) begin errors++; $display("FAIL rst_async_abort got %b want 0", o_rst_dsp); end
    @(negedge clk); i_reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ram_read();
    bit ack;
    i_ram_rdata = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    send_cmd(32'h0481_0123, ack);
    checks++; if (!ack || o_ram_rd_adrs !== 16'h0123) begin errors++; $display("FAIL ram_adrs got ack=%b adrs=%h want 1/0123", ack, o_ram_rd_adrs); end
    checks++; if (o_ram_rd_en !== 1'b1) begin errors++; $display("FAIL ram_rd_en got %b want 1", o_ram_rd_en); end
    @(negedge clk);
    begin
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++; if (o_gpio_rdata !== e) begin errors++; $display("FAIL ram_rdata got %h want %h", o_gpio_rdata, e); end
    end
  endtask

  task automatic test_status();
    bit ack;
    logic [31:0] e;
    exp_q.push_back(32'h0440_0200);
    send_cmd(32'h0780_0001, ack);
    checks++; if (!ack || o_ram_rd_en !== 1'b0) begin errors++; $display("FAIL sts_excl got ack=%b ram_rd_en=%b want 1/0", ack, o_ram_rd_en); end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (o_gpio_rdata !== e) begin errors++; $display("FAIL sts_rdata got %h want %h", o_gpio_rdata, e); end
  endtask

  task automatic test_unknown();
    bit ack;
    send_cmd(32'h0380_0006, ack);
    send_cmd(32'h0980_0001, ack);
    checks++; if (ack) begin errors++; $display("FAIL unk_ack got %b want 0", ack); end
    checks++; if (o_log_sel !== 3'd6 || o_log_wr_en !== 1'b0) begin errors++; $display("FAIL unk_log got %0d/%b want 6/0", o_log_sel, o_log_wr_en); end
    checks++; if (o_ram_rd_adrs !== 16'h0123 || o_ram_rd_en !== 1'b0) begin errors++; $display("FAIL unk_ram got %h/%b want 0123/0", o_ram_rd_adrs, o_ram_rd_en); end
    checks++; if (o_gpio_rdata !== 32'h0440_0200) begin errors++; $display("FAIL unk_rdata got %h want 04400200", o_gpio_rdata); end
  endtask

  task automatic test_cnt_read();
    bit ack;
    logic [31:0] e;
    logic [31:0] cmds [5];
    logic [31:0] exps [5];
    i_cnt_flat[0*64 +: 64] = 64'hA0A0_0001_A0A0_0000;
    i_cnt_flat[1*64 +: 64] = 64'h0000_0005_0000_0007;
    i_cnt_flat[2*64 +: 64] = 64'hC2C2_1111_C2C2_2222;
    i_cnt_flat[3*64 +: 64] = 64'h3333_4444_5555_6666;
    send_cmd(32'h0580_0001, ack);
    checks++; if (!ack || o_snap_valid !== 1'b1) begin errors++; $display("FAIL snap_valid got ack=%b valid=%b want 1/1", ack, o_snap_valid); end
    i_cnt_flat[1*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
    cmds = '{32'h0680_0102, 32'h0680_0103, 32'h0680_0108, 32'h0680_0107, 32'h0780_0001};
    exps = '{32'h0000_0007, 32'h0000_0005, 32'h0000_0000, 32'h3333_4444, 32'h0440_0201};
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(exps[k]);
      send_cmd(cmds[k], ack);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (!ack || o_gpio_rdata !== e) begin errors++; $display("FAIL cnt_read_%0d got ack=%b rdata=%h want %h", k, ack, o_gpio_rdata, e); end
    end
  endtask

  task automatic test_continuous();
    bit ack;
    logic [31:0] e;
    logic [31:0] frozen;
    i_cnt_flat[0 +: 64] = 64'h100;
    send_cmd(32'h0680_0100, ack);
    send_cmd(32'h0580_0002, ack);
    checks++; if (!ack || o_snap_valid !== 1'b1) begin errors++; $display("FAIL cont_valid got ack=%b valid=%b want 1/1", ack, o_snap_valid); end
    repeat (3) @(negedge clk);
    exp_q.delete();
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h100);
    for (int i = 0; i < 20; i++) begin
      i_cnt_flat[0 +: 64] = i_cnt_flat[0 +: 64] + 64'd1;
      exp_q.push_back(i_cnt_flat[31:0]);
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        checks++; if (o_gpio_rdata !== e) begin errors++; $display("FAIL cont_track_%0d got %h want %h", i, o_gpio_rdata, e); end
      end
      @(negedge clk);
    end
    frozen = i_cnt_flat[31:0];
    exp_q.delete();
    send_cmd(32'h0580_0000, ack);
    checks++; if (!ack || o_snap_valid !== 1'b0) begin errors++; $display("FAIL cont_stop got ack=%b valid=%b want 1/0", ack, o_snap_valid); end
    for (int i = 0; i < 5; i++) begin
      i_cnt_flat[0 +: 64] = i_cnt_flat[0 +: 64] + 64'd3;
      exp_q.push_back(frozen);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (o_gpio_rdata !== e) begin errors++; $display("FAIL cont_frozen_%0d got %h want %h", i, o_gpio_rdata, e); end
    end
  endtask

  task automatic test_strobe_reset();
    int acks;
    acks = 0;
    i_gpio_cmd = 32'h0380_000C;
    @(negedge clk); i_reset = 1'b0;
    @(negedge clk); i_reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_cmd_ack === 1'b1) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL held_strobe_ack got %0d want 0", acks); end
    checks++; if (o_log_sel !== 3'd0 || o_log_wr_en !== 1'b0) begin errors++; $display("FAIL held_strobe_log got %0d/%b want 0/0", o_log_sel, o_log_wr_en); end
  endtask

  initial begin
    test_reset();
    test_log();
    test_rst_pulse();
    test_ram_read();
    test_status();
    test_unknown();
    test_cnt_read();
    test_continuous();
    test_strobe_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_regfile.md
Name: gpio_regfile

Overview:
Parametrised command/register file between the MicroBlaze GPIO pair and the QPSK DSP datapath.
- Decodes 32-bit GPIO command words (opcode[31:24], strobe[23], payload[22:0]) into control registers for DSP soft reset, RAM logging and RAM readback.
- Takes atomic snapshots of NUM_CH wide BER counters.
- Returns one selected read source on the GPIO input bus.
- Replaces the inline always-block register file in top; adds edge-triggered strobing, timed soft reset, generic channel/word counter readback, a status word and a command acknowledge.

Parameters:
- NBT_GPIOS, 32, GPIO bus width.
- NB_CNT, 64, width of each counter; must be a multiple of NBT_GPIOS.
- NUM_CH, 4, number of counters (err_I, bit_I, err_Q, bit_Q order); 1..16.
- NBT_ADRS, 16, RAM read-address width (≤16).
- RST_CYCLES, 16, soft-reset pulse length in clocks (≥1).

Ports:
- clk, in, 1, system clock.
- i_reset, in, 1, asynchronous active-low reset.
- i_gpio_cmd, in, NBT_GPIOS, command word from MicroBlaze GPIO output.
- o_gpio_rdata, out, NBT_GPIOS, read data to MicroBlaze GPIO input.
- i_ram_rdata, in, NBT_GPIOS, data from block_ram_control.
- i_cnt_flat, in, NUM_CH*NB_CNT, counters; channel k at [k*NB_CNT +: NB_CNT].
- o_rst_dsp, out, 1, soft reset to DSP, active-high.
- o_log_sel, out, 3, log data select.
- o_log_wr_en, out, 1, RAM logging enable.
- o_ram_rd_en, out, 1, RAM read enable.
- o_ram_rd_adrs, out, NBT_ADRS, RAM read address.
- o_snap_valid, out, 1, snapshot registers hold captured data.
- o_cmd_ack, out, 1, one-cycle pulse per accepted command.

Behaviour:
- Reset (i_reset=0, async): all outputs, snapshot registers, read-enable flags and soft-reset counter are 0; strobe history is 1, so a strobe held high through reset is not accepted.
- Acceptance: a command is accepted on the clock edge where cmd[23]=1 and the previous sampled cmd[23]=0 (rising edge). A held strobe executes exactly once. Register updates are visible after that edge; o_cmd_ack pulses the following cycle.
- Unknown opcodes are ignored: no state change, no ack.
- 0x01, soft reset:
  - bit0=1: o_rst_dsp=1; load counter with RST_CYCLES; decrement each cycle; deassert when it reaches 0. o_rst_dsp is high for exactly RST_CYCLES cycles.
  - Re-issuing while active reloads the counter.
  - bit0=0: deassert immediately and clear the counter.
- 0x03, logging: o_log_sel<=cmd[2:0], o_log_wr_en<=cmd[3].
- 0x04, RAM read: ram_rd_en<=cmd[16], o_ram_rd_adrs<=cmd[NBT_ADRS-1:0].
- 0x05, snapshot:
  - bit0=1: capture all NUM_CH counters in the same cycle; o_snap_valid=1 from the next cycle.
  - bit1=1: continuous mode; capture every cycle until a 0x05 with bit1=0 arrives.
  - bit0=0 and bit1=0: stop continuous mode; clear o_snap_valid; keep contents.
- 0x06, counter read: cnt_rd_en<=cmd[8], cnt_idx<=cmd[7:0].
  - Index decode: word=idx mod W, ch=idx/W, where W=NB_CNT/NBT_GPIOS; word 0 is the LS word.
  - Index ≥ NUM_CH*W reads 0.
- 0x07, status read: sts_rd_en<=cmd[0].
  - Status word: {NUM_CH[7:0], NB_CNT[7:0], version 8'h02, 7'b0, o_snap_valid}, truncated or zero-padded to NBT_GPIOS.
- Read enables are mutually exclusive: accepting 0x04, 0x06 or 0x07 with its enable=1 clears the other two flags.
- o_gpio_rdata is registered. Each cycle it loads the selected source (RAM, snapshot word, status), or 0 if no read is enabled. Latency is 1 cycle from register/snapshot change; RAM latency adds on top.
- Snapshot and counter read in the same cycle: the read returns the new value one cycle later, never a mixed-channel value.
- o_rst_dsp does not reset this block.
- Asserting i_reset mid-pulse ends the pulse at once.

Optional Feature:
- Macro: GPIO_REGFILE_CDC_SYNC_EN.
- Defined: i_gpio_cmd passes through a 2-flop synchronizer, captured only when two consecutive samples agree. Acceptance latency becomes +3 cycles; ack follows accordingly.
- Undefined: i_gpio_cmd is sampled directly, so the GPIO must be synchronous to clk.

Decomposition:
- Package gpio_regfile_pkg holds:
  - opcode constants OPC_RST=8'h01, OPC_LOG=8'h03, OPC_RAM_RD=8'h04, OPC_SNAP=8'h05, OPC_CNT_RD=8'h06, OPC_STS=8'h07;
  - STROBE_BIT=23;
  - REGFILE_VERSION=8'h02;
  - read-source select enum.
- One sub-module, cnt_snapshot: NUM_CH×NB_CNT capture registers plus the word-select mux, with single/continuous capture inputs.

Test Plan:
- Reset, then cmd=0x03800A0B held for 10 cycles: o_log_sel=3, o_log_wr_en=1; exactly one o_cmd_ack pulse.
- cmd=0x01800001: o_rst_dsp high for exactly 16 cycles. Re-issue at cycle 8 (strobe low then high): pulse extends to 24 cycles total.
- i_cnt_flat ch1=64'h0000_0005_0000_0007; send 0x05800001, then 0x06800102 then 0x06800103 (ch1 words 0, 1): rdata=0x7, then 0x5. Index 8 reads 0.
- 0x04810123 with i_ram_rdata=0xDEADBEEF: o_ram_rd_adrs=0x0123, rdata=0xDEADBEEF. Then 0x07800001: rdata=0x04400200 (valid=0 before snapshot); o_ram_rd_en=0.
- Unknown opcode 0x09800001: no ack, no register change. Strobe held high across reset release: not accepted.
- Continuous snapshot 0x05800002 with incrementing counters: reads track them at 1-cycle latency. 0x05800000 freezes the values and clears o_snap_valid.
